// File: rtl/sr_reg_fifo_pkg.sv
// Shared constants for the register-backed FIFO and its decode in the single-cycle core.
// Custom-0 opcode space carries the FIFO instructions; funct3 selects PUSH or POP.
package sr_reg_fifo_pkg;

    localparam logic [6:0] RVOP_FIFO      = 7'b0001011;
    localparam logic [2:0] RVF3_FIFO_PUSH = 3'b000;
    localparam logic [2:0] RVF3_FIFO_POP  = 3'b001;

    // Default depth used by the sr_cpu instance.
    localparam int SR_FIFO_DEPTH = 8;

    // True when an instruction word decodes as a FIFO PUSH/POP.
    function automatic logic is_fifo_op(input logic [31:0] instr);
        return (instr[6:0] == RVOP_FIFO) &&
               ((instr[14:12] == RVF3_FIFO_PUSH) || (instr[14:12] == RVF3_FIFO_POP));
    endfunction

endpackage

// File: rtl/sr_fifo_mem.sv
// Storage for sr_reg_fifo: DEPTH x DATA_WIDTH, one synchronous write port and
// one asynchronous read port. Contents are intentionally not reset.
module sr_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write the tail entry on the clock edge.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Head entry is visible combinationally so pop data is ready in the request cycle.
    always_comb begin
        rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/sr_reg_fifo.sv
// Register-backed FIFO between the register file and writeback.
// PUSH enqueues rs1; POP returns the head word in the same cycle as rd write data.
// Optional feature: define SR_FIFO_ERR_EN to add sticky overflow/underflow flags.
module sr_reg_fifo
    import sr_reg_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = SR_FIFO_DEPTH,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  writeEnable,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  readEnable,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_W:0]       count
`ifdef SR_FIFO_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic [DATA_WIDTH-1:0] head;
    logic push_ok, pop_ok;

    assign full  = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // A push into a full FIFO is allowed only when the head is leaving the same cycle.
    // Pop on empty is always rejected, so push+pop on empty is just a push (no bypass).
    assign push_ok = writeEnable & (~full | readEnable);
    assign pop_ok  = readEnable & ~empty;

    sr_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (ADDR_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (push_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (writeData),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // Empty reads return zero so rd gets a defined value on an underflowing POP.
    assign readData = empty ? '0 : head;

    // Next-state for pointers and occupancy; pointers wrap by natural rollover.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        if (push_ok && !pop_ok) count_d = count_q + (ADDR_W+1)'(1);
        if (pop_ok && !push_ok) count_d = count_q - (ADDR_W+1)'(1);
    end

    // Pointer/occupancy registers; reset discards all contents immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef SR_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags; only cleared by reset.
    always_comb begin
        overflow_d  = overflow_q  | (writeEnable & full & ~readEnable);
        underflow_d = underflow_q | (readEnable & empty);
    end

    // Error flag registers for the debug path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sr_reg_fifo.sv
// Directed bench for sr_reg_fifo (DEPTH=8, DATA_WIDTH=32).
// Inputs change 1ns after posedge; outputs are sampled mid-cycle.
module tb_sr_reg_fifo;

    localparam int DW = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          writeEnable;
    logic [DW-1:0] writeData;
    logic          readEnable;
    logic [DW-1:0] readData;
    logic          full, empty;
    logic [3:0]    count;
`ifdef SR_FIFO_ERR_EN
    logic          overflow, underflow;
`endif

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    sr_reg_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .writeEnable (writeEnable),
        .writeData   (writeData),
        .readEnable  (readEnable),
        .readData    (readData),
        .full        (full),
        .empty       (empty),
        .count       (count)
`ifdef SR_FIFO_ERR_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [DW-1:0] wd, input logic re);
        writeEnable = we;
        writeData   = wd;
        readEnable  = re;
        #1;
    endtask

    task automatic push(input logic [DW-1:0] wd);
        drive(1'b1, wd, 1'b0);
        tick();
    endtask

    task automatic pop_chk(input string tag, input logic [DW-1:0] exp);
        drive(1'b0, '0, 1'b1);
        chk(tag, readData, exp);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        writeEnable = 1'b0;
        writeData = '0;
        readEnable = 1'b0;
        #12;
        // 1. reset / idle
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_rdata", readData, 0);
`ifdef SR_FIFO_ERR_EN
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_udf", 32'(underflow), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_count", 32'(count), 0);

        // 2. three pushes, three pops
        push(32'h11); push(32'h22); push(32'h33);
        chk("t2_count", 32'(count), 3);
        pop_chk("t2_pop0", 32'h11);
        pop_chk("t2_pop1", 32'h22);
        pop_chk("t2_pop2", 32'h33);
        chk("t2_empty", 32'(empty), 1);

        // 3. fill, drop on full, drain
        for (int i = 1; i <= 8; i++) push(32'(i));
        chk("t3_full", 32'(full), 1);
        chk("t3_count", 32'(count), 8);
        push(32'h99);
        chk("t3_drop_count", 32'(count), 8);
`ifdef SR_FIFO_ERR_EN
        chk("t3_ovf", 32'(overflow), 1);
`endif
        for (int i = 1; i <= 8; i++) pop_chk($sformatf("t3_pop%0d", i), 32'(i));
        chk("t3_empty", 32'(empty), 1);

        // 4. simultaneous push/pop while full
        for (int i = 1; i <= 8; i++) push(32'(i));
        drive(1'b1, 32'hAA, 1'b1);
        chk("t4_head", readData, 1);
        tick();
        chk("t4_count", 32'(count), 8);
        chk("t4_full", 32'(full), 1);
        for (int i = 2; i <= 8; i++) pop_chk($sformatf("t4_pop%0d", i), 32'(i));
        pop_chk("t4_popAA", 32'hAA);
        chk("t4_empty", 32'(empty), 1);

        // 5. pop on empty, then push+pop on empty
        pop_chk("t5_udf_rdata", 0);
        chk("t5_udf_count", 32'(count), 0);
`ifdef SR_FIFO_ERR_EN
        chk("t5_udf", 32'(underflow), 1);
`endif
        drive(1'b1, 32'h5, 1'b1);
        chk("t5_pp_rdata", readData, 0);
        tick();
        chk("t5_pp_count", 32'(count), 1);
        pop_chk("t5_pop5", 32'h5);
        chk("t5_empty", 32'(empty), 1);

        // 6. 20 push/pop pairs across pointer wrap, then async reset
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h100 + 32'(i), i > 0);
            if (i > 0) chk($sformatf("t6_pair%0d", i), readData, 32'h100 + 32'(i) - 1);
            tick();
        end
        chk("t6_count", 32'(count), 1);
        push(32'h200); push(32'h201);
        chk("t6_pre_rst_count", 32'(count), 3);
        drive(1'b0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_count", 32'(count), 0);
        chk("t6_rst_empty", 32'(empty), 1);
        chk("t6_rst_rdata", readData, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        pop_chk("t6_post_rst_pop", 0);
        chk("t6_post_rst_count", 32'(count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
